// File: rtl/rx_command_decoder.sv
// Turns the UART receive byte stream into minesweeper cursor moves and
// reveal/flag/new-game commands handed to the game core over valid/ready.
module rx_command_decoder #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int ROW_W = 4,
  parameter int COL_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       rxdata,
  input  logic             rxfinish,
  output logic [ROW_W-1:0] cursor_row,
  output logic [COL_W-1:0] cursor_col,
  output logic             cmd_valid,
  output logic [1:0]       cmd_code,
  output logic [ROW_W-1:0] cmd_row,
  output logic [COL_W-1:0] cmd_col,
  input  logic             cmd_ready,
  output logic             err,
  output logic [1:0]       err_code
);

  typedef enum logic [1:0] {IDLE, GOTO_ROW, GOTO_COL} state_e;

  localparam logic [1:0] CMD_REVEAL   = 2'd0;
  localparam logic [1:0] CMD_FLAG     = 2'd1;
  localparam logic [1:0] CMD_NEW      = 2'd2;
  localparam logic [1:0] ERR_UNKNOWN  = 2'd0;
  localparam logic [1:0] ERR_DIGIT    = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW = 2'd2;

  localparam logic [7:0] ESC = 8'h1B;
  localparam logic [3:0] ROWS_L = 4'(ROWS);
  localparam logic [3:0] COLS_L = 4'(COLS);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);

  state_e           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d, goto_row_q, goto_row_d, cmd_row_q, cmd_row_d;
  logic [COL_W-1:0] col_q, col_d, cmd_col_q, cmd_col_d;
  logic             cmd_valid_q, cmd_valid_d, err_q, err_d;
  logic [1:0]       cmd_code_q, cmd_code_d, err_code_q, err_code_d;

  logic [7:0] upper;
  logic [3:0] digit;
  logic       is_digit, row_ok, col_ok, is_esc;
  logic       issue, new_game, cmd_busy;
  logic [1:0] issue_code;

  // Letters are folded to upper case; the digit value is validated before use.
  always_comb begin
    upper    = (rxdata >= 8'h61 && rxdata <= 8'h7A) ? rxdata - 8'h20 : rxdata;
    digit    = 4'(rxdata - 8'h30);
    is_digit = (rxdata >= 8'h30) && (rxdata <= 8'h39);
    row_ok   = is_digit && (digit < ROWS_L);
    col_ok   = is_digit && (digit < COLS_L);
    is_esc   = (rxdata == ESC);
    cmd_busy = cmd_valid_q && !cmd_ready;
  end

  // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (rxfinish) begin
      case (state_q)
        IDLE:     if (upper == "G") state_d = GOTO_ROW;
        GOTO_ROW: state_d = (!is_esc && row_ok) ? GOTO_COL : IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    row_d       = row_q;
    col_d       = col_q;
    goto_row_d  = goto_row_q;
    cmd_valid_d = cmd_valid_q && !cmd_ready;
    cmd_code_d  = cmd_code_q;
    cmd_row_d   = cmd_row_q;
    cmd_col_d   = cmd_col_q;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    issue       = 1'b0;
    new_game    = 1'b0;
    issue_code  = CMD_REVEAL;

    if (rxfinish) begin
      case (state_q)
        IDLE: begin
          case (upper)
            "W": row_d = (row_q == '0) ? ROW_MAX : row_q - ROW_W'(1);
            "S": row_d = (row_q == ROW_MAX) ? '0 : row_q + ROW_W'(1);
            "A": col_d = (col_q == '0) ? COL_MAX : col_q - COL_W'(1);
            "D": col_d = (col_q == COL_MAX) ? '0 : col_q + COL_W'(1);
            "R", " ": issue = 1'b1;
            "F": begin issue = 1'b1; issue_code = CMD_FLAG; end
            "N": begin issue = 1'b1; issue_code = CMD_NEW; new_game = 1'b1; end
            "G", 8'h0D, 8'h0A: ;
            default: begin err_d = 1'b1; err_code_d = ERR_UNKNOWN; end
          endcase
        end
        GOTO_ROW: begin
          if (is_esc) ;
          else if (row_ok) goto_row_d = ROW_W'(digit);
          else begin err_d = 1'b1; err_code_d = ERR_DIGIT; end
        end
        default: begin
          if (is_esc) ;
          else if (col_ok) begin
            row_d = goto_row_q;
            col_d = COL_W'(digit);
          end else begin err_d = 1'b1; err_code_d = ERR_DIGIT; end
        end
      endcase
    end

    // A command byte while the core is still holding off drops the byte.
    if (issue) begin
      if (cmd_busy) begin
        err_d      = 1'b1;
        err_code_d = ERR_OVERFLOW;
      end else begin
        cmd_valid_d = 1'b1;
        cmd_code_d  = issue_code;
        cmd_row_d   = row_q;
        cmd_col_d   = col_q;
        if (new_game) begin
          row_d = '0;
          col_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row_q       <= '0;
      col_q       <= '0;
      goto_row_q  <= '0;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= '0;
      cmd_row_q   <= '0;
      cmd_col_q   <= '0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
    end else begin
      row_q       <= row_d;
      col_q       <= col_d;
      goto_row_q  <= goto_row_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
      cmd_row_q   <= cmd_row_d;
      cmd_col_q   <= cmd_col_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign cursor_row = row_q;
  assign cursor_col = col_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_code   = cmd_code_q;
  assign cmd_row    = cmd_row_q;
  assign cmd_col    = cmd_col_q;
  assign err        = err_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_rx_command_decoder.sv
// Directed scenarios plus randomized byte streams for rx_command_decoder,
// compared against an integer-arithmetic model of the command language.
module tb_rx_command_decoder;

  localparam int ROWS = 8;
  localparam int COLS = 8;

  logic       clock, reset, rxfinish, cmd_ready, cmd_valid, err;
  logic [7:0] rxdata;
  logic [3:0] cursor_row, cursor_col, cmd_row, cmd_col;
  logic [1:0] cmd_code, err_code;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: cursor, pending goto digits (0 none, 1 want row, 2 want col), command, error.
  int m_row, m_col, m_goto, m_grow, m_valid, m_code, m_crow, m_ccol, m_err, m_errc;

  rx_command_decoder #(.ROWS(ROWS), .COLS(COLS), .ROW_W(4), .COL_W(4)) dut (
    .clock(clock), .reset(reset), .rxdata(rxdata), .rxfinish(rxfinish),
    .cursor_row(cursor_row), .cursor_col(cursor_col),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .cmd_ready(cmd_ready), .err(err), .err_code(err_code)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic model_reset();
    m_row = 0; m_col = 0; m_goto = 0; m_grow = 0; m_valid = 0;
    m_code = 0; m_crow = 0; m_ccol = 0; m_err = 0; m_errc = 0;
  endtask

  task automatic model_step(input logic [7:0] b, input logic strobe, input logic rdy);
    int  c, d;
    bit  busy;
    m_err = 0;
    busy = (m_valid != 0) && !rdy;
    m_valid = busy ? 1 : 0;
    if (!strobe) return;
    c = int'(b);
    if (c >= 97 && c <= 122) c -= 32;
    d = int'(b) - 48;
    if (m_goto == 0) begin
      if (c == 87) m_row = (m_row + ROWS - 1) % ROWS;
      else if (c == 83) m_row = (m_row + 1) % ROWS;
      else if (c == 65) m_col = (m_col + COLS - 1) % COLS;
      else if (c == 68) m_col = (m_col + 1) % COLS;
      else if (c == 82 || c == 32 || c == 70 || c == 78) begin
        if (busy) begin m_err = 1; m_errc = 2; end
        else begin
          m_valid = 1;
          m_code  = (c == 70) ? 1 : (c == 78) ? 2 : 0;
          m_crow  = m_row;
          m_ccol  = m_col;
          if (c == 78) begin m_row = 0; m_col = 0; end
        end
      end
      else if (c == 71) m_goto = 1;
      else if (c == 13 || c == 10) ;
      else begin m_err = 1; m_errc = 0; end
    end else if (b == 8'h1B) begin
      m_goto = 0;
    end else if (d >= 0 && d <= 9 && d < ((m_goto == 1) ? ROWS : COLS)) begin
      if (m_goto == 1) begin m_grow = d; m_goto = 2; end
      else begin m_row = m_grow; m_col = d; m_goto = 0; end
    end else begin
      m_err = 1; m_errc = 1; m_goto = 0;
    end
  endtask

  // Drives one cycle of inputs, steps the model, and returns 1 time unit after the edge.
  task automatic step(input logic [7:0] b, input logic strobe, input logic rdy);
    rxdata = b; rxfinish = strobe; cmd_ready = rdy;
    model_step(b, strobe, rdy);
    @(posedge clock);
    #1;
    rxfinish = 1'b0; cmd_ready = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    step(b, 1'b1, 1'b0);
  endtask

  task automatic apply_reset();
    rxfinish = 1'b0; cmd_ready = 1'b0; rxdata = 8'h00;
    reset = 1'b0;
    #5;
    reset = 1'b1;
    model_reset();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; rxfinish = 1'b0; cmd_ready = 1'b0; rxdata = 8'h00;
    #12;
    n_checks++;
    if ({cursor_row, cursor_col, cmd_valid, cmd_code, cmd_row, cmd_col, err, err_code} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_state got %h want 0",
               {cursor_row, cursor_col, cmd_valid, cmd_code, cmd_row, cmd_col, err, err_code});
    end
    apply_reset();
    send("D"); send("D"); send("s");
    n_checks++;
    if ({cursor_row, cursor_col, err, cmd_valid} !== {4'd1, 4'd2, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_moves got row=%0d col=%0d err=%b valid=%b want 1 2 0 0",
               cursor_row, cursor_col, err, cmd_valid);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    send("w"); send("A");
    n_checks++;
    if ({cursor_row, cursor_col} !== {4'd7, 4'd7}) begin
      n_fail++;
      $display("FAIL wrap_low got (%0d,%0d) want (7,7)", cursor_row, cursor_col);
    end
    send("S"); send("d");
    n_checks++;
    if ({cursor_row, cursor_col} !== {4'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL wrap_high got (%0d,%0d) want (0,0)", cursor_row, cursor_col);
    end
  endtask

  task automatic test_goto_flag();
    apply_reset();
    send("G"); send("5"); send("3");
    n_checks++;
    if ({cursor_row, cursor_col, err} !== {4'd5, 4'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL goto got (%0d,%0d) err=%b want (5,3) 0", cursor_row, cursor_col, err);
    end
    send("F");
    step(8'h00, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    n_checks++;
    if ({cmd_valid, cmd_code, cmd_row, cmd_col} !== {1'b1, 2'd1, 4'd5, 4'd3}) begin
      n_fail++;
      $display("FAIL flag_held got v=%b code=%0d (%0d,%0d) want 1 1 (5,3)",
               cmd_valid, cmd_code, cmd_row, cmd_col);
    end
    step(8'h00, 1'b0, 1'b1);
    n_checks++;
    if (cmd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flag_accept got valid=%b want 0", cmd_valid);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    send("D"); send("R");
    send("N");
    n_checks++;
    if ({err, err_code, cmd_valid, cmd_code, cmd_row, cmd_col, cursor_row, cursor_col} !==
        {1'b1, 2'd2, 1'b1, 2'd0, 4'd0, 4'd1, 4'd0, 4'd1}) begin
      n_fail++;
      $display("FAIL overflow got err=%b code=%0d v=%b cmd=%0d (%0d,%0d) cur=(%0d,%0d)",
               err, err_code, cmd_valid, cmd_code, cmd_row, cmd_col, cursor_row, cursor_col);
    end
    send("S");
    n_checks++;
    if ({cmd_valid, cmd_row, cursor_row, err} !== {1'b1, 4'd0, 4'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL move_while_pending got v=%b cmd_row=%0d row=%0d err=%b want 1 0 1 0",
               cmd_valid, cmd_row, cursor_row, err);
    end
    step("R", 1'b1, 1'b1);
    n_checks++;
    if ({cmd_valid, cmd_code, cmd_row, cmd_col, err} !== {1'b1, 2'd0, 4'd1, 4'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL back_to_back got v=%b code=%0d (%0d,%0d) err=%b want 1 0 (1,1) 0",
               cmd_valid, cmd_code, cmd_row, cmd_col, err);
    end
    step(8'h00, 1'b0, 1'b1);
    send("n");
    n_checks++;
    if ({cmd_valid, cmd_code, cmd_row, cmd_col, cursor_row, cursor_col} !==
        {1'b1, 2'd2, 4'd1, 4'd1, 4'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL new_game got v=%b code=%0d (%0d,%0d) cur=(%0d,%0d) want 1 2 (1,1) (0,0)",
               cmd_valid, cmd_code, cmd_row, cmd_col, cursor_row, cursor_col);
    end
  endtask

  task automatic test_goto_errors();
    apply_reset();
    send("D");
    send("G"); send("9");
    n_checks++;
    if ({err, err_code, cursor_row, cursor_col} !== {1'b1, 2'd1, 4'd0, 4'd1}) begin
      n_fail++;
      $display("FAIL row_range got err=%b code=%0d (%0d,%0d) want 1 1 (0,1)",
               err, err_code, cursor_row, cursor_col);
    end
    send("d");
    n_checks++;
    if ({err, cursor_col} !== {1'b0, 4'd2}) begin
      n_fail++;
      $display("FAIL idle_after_err got err=%b col=%0d want 0 2", err, cursor_col);
    end
    send("G"); send("2"); send(8'h1B);
    n_checks++;
    if ({err, cursor_row, cursor_col} !== {1'b0, 4'd0, 4'd2}) begin
      n_fail++;
      $display("FAIL esc_abort got err=%b (%0d,%0d) want 0 (0,2)", err, cursor_row, cursor_col);
    end
    send("g"); send("3"); send("8");
    n_checks++;
    if ({err, err_code, cursor_row, cursor_col} !== {1'b1, 2'd1, 4'd0, 4'd2}) begin
      n_fail++;
      $display("FAIL col_range got err=%b code=%0d (%0d,%0d) want 1 1 (0,2)",
               err, err_code, cursor_row, cursor_col);
    end
    send("x");
    n_checks++;
    if ({err, err_code} !== {1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL unknown_byte got err=%b code=%0d want 1 0", err, err_code);
    end
    step(8'h78, 1'b0, 1'b0);
    n_checks++;
    if ({err, err_code} !== {1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL err_pulse_width got err=%b code=%0d want 0 0", err, err_code);
    end
    send(8'h0D); send(8'h0A);
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL crlf_ignored got err=%b want 0", err);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    send("S"); send("D"); send("R");
    send("G"); send("4");
    #3;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({cursor_row, cursor_col, cmd_valid, cmd_code, cmd_row, cmd_col, err, err_code} !== 22'd0) begin
      n_fail++;
      $display("FAIL async_reset got %h want 0",
               {cursor_row, cursor_col, cmd_valid, cmd_code, cmd_row, cmd_col, err, err_code});
    end
    #2;
    reset = 1'b1;
    model_reset();
    send("3");
    n_checks++;
    if ({err, err_code, cursor_row, cursor_col} !== {1'b1, 2'd0, 4'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL reset_leaves_goto got err=%b code=%0d (%0d,%0d) want 1 0 (0,0)",
               err, err_code, cursor_row, cursor_col);
    end
  endtask

  task automatic test_random();
    logic [7:0]  pool [0:17] = '{8'h77, 8'h61, 8'h73, 8'h64, 8'h57, 8'h41, 8'h53, 8'h44, 8'h72,
                                 8'h52, 8'h20, 8'h66, 8'h46, 8'h4E, 8'h6E, 8'h0D, 8'h0A, 8'h1B};
    logic [7:0]  b;
    logic [21:0] act, exp;
    int          sel;
    apply_reset();
    for (int i = 0; i < 1500; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 4)      b = pool[$urandom_range(0, 17)];
      else if (sel <= 7) b = 8'(8'h30 + $urandom_range(0, 9));
      else if (sel == 8) b = 8'($urandom_range(0, 255));
      else               b = 8'h47;
      step(b, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3));
      act = {cursor_row, cursor_col, cmd_valid, cmd_code, cmd_row, cmd_col, err, err_code};
      exp = {4'(m_row), 4'(m_col), 1'(m_valid), 2'(m_code), 4'(m_crow), 4'(m_ccol),
             1'(m_err), 2'(m_errc)};
      n_checks++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL random[%0d] byte=%h got cur=(%0d,%0d) v=%b code=%0d cmd=(%0d,%0d) err=%b ec=%0d want %h",
                 i, b, cursor_row, cursor_col, cmd_valid, cmd_code, cmd_row, cmd_col,
                 err, err_code, exp);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_wrap();
    test_goto_flag();
    test_overflow();
    test_goto_errors();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_command_decoder.md
Name: rx_command_decoder

Overview:
Consumes the byte stream produced by the UART receive stage (`rxdata` plus the 1-cycle `rxfinish` strobe) and turns it into minesweeper game actions.
- Maintains the board cursor and parses single-byte moves and actions, plus a 3-byte "goto" sequence.
- Presents reveal/flag/new-game commands to the game core through a valid/ready handshake.
- Sits between the UART receiver and the board/game controller.

Parameters:
- ROWS, 8, number of board rows (2..10).
- COLS, 8, number of board columns (2..10).
- ROW_W, 4, width of row fields; must satisfy 2^ROW_W >= ROWS.
- COL_W, 4, width of column fields; must satisfy 2^COL_W >= COLS.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- rxdata  in  8  received byte; valid only in a cycle where rxfinish=1.
- rxfinish  in  1  1-cycle strobe: rxdata holds a new byte.
- cursor_row  out  ROW_W  current cursor row.
- cursor_col  out  COL_W  current cursor column.
- cmd_valid  out  1  command pending for the game core.
- cmd_code  out  2  command code: 0=reveal, 1=flag, 2=new game.
- cmd_row  out  ROW_W  cursor row captured when the command was issued.
- cmd_col  out  COL_W  cursor column captured when the command was issued.
- cmd_ready  in  1  game core accepts the pending command this cycle.
- err  out  1  1-cycle error pulse.
- err_code  out  2  error cause: 0=unknown byte, 1=bad/out-of-range digit, 2=overflow. Held until the next err pulse.

Behaviour:
- Reset (reset=0, asynchronous), all outputs 0:
  - cursor at (0,0); cmd_valid=0, cmd_code=0, cmd_row=0, cmd_col=0; err=0, err_code=0; FSM in IDLE.
- Bytes are sampled only in cycles with rxfinish=1.
- Latency: a byte strobed in cycle N has its effect visible in cycle N+1 (single register stage).
- Letter bytes are case-insensitive.
- FSM states: IDLE, GOTO_ROW, GOTO_COL.
- IDLE byte handling:
  - 'W': row-1, wraps 0 -> ROWS-1.
  - 'S': row+1, wraps ROWS-1 -> 0.
  - 'A': col-1, wraps 0 -> COLS-1.
  - 'D': col+1, wraps COLS-1 -> 0.
  - 'R' or ' ' (0x20): issue reveal.
  - 'F': issue flag.
  - 'N': issue new game, and reset the cursor to (0,0) in the same edge. cmd_row/cmd_col capture the pre-reset cursor.
  - 'G': go to GOTO_ROW.
  - CR (0x0D), LF (0x0A): ignored, no error.
  - Any other byte: err pulse, err_code=0.
- GOTO_ROW:
  - ASCII digit '0'..'9' with value < ROWS: latch it, go to GOTO_COL.
  - ESC (0x1B): return to IDLE silently.
  - Any other byte, or digit >= ROWS: err pulse, err_code=1, return to IDLE, cursor unchanged.
- GOTO_COL:
  - Digit with value < COLS: cursor <= (latched row, digit), return to IDLE.
  - ESC and bad/out-of-range input: handled as in GOTO_ROW.
- Issuing a command: cmd_valid<=1; cmd_code set; cmd_row/cmd_col <= cursor value before this edge.
- Handshake:
  - cmd_valid, cmd_code, cmd_row and cmd_col stay stable while cmd_valid=1 and cmd_ready=0.
  - The command completes in a cycle with cmd_valid=1 and cmd_ready=1; cmd_valid drops next cycle unless a new command is issued in that same cycle.
  - cmd_ready while cmd_valid=0 is ignored.
- Overflow: a command byte ('R', ' ', 'F', 'N') arriving while cmd_valid=1 and cmd_ready=0:
  - byte is dropped; err pulse with err_code=2; pending command unchanged.
  - for 'N', the cursor is also not reset.
- Moves and goto sequences proceed normally while a command is pending.
- Simultaneous handshake and new command byte (cmd_valid=1, cmd_ready=1, rxfinish=1): the old command is accepted and the new one loads, so cmd_valid stays 1 with new contents.
- err is high for exactly one cycle per error; it is never asserted without a strobe.
- Reset mid-sequence (e.g. in GOTO_COL) or with a command pending: returns to IDLE and clears everything immediately, without waiting for a clock edge.
- Arithmetic: cursor wrap uses compare against ROWS-1/COLS-1, not power-of-two overflow. The digit value is rxdata-0x30, checked before use.

Test Plan:
- Reset, then strobe 'D','D','s' -> cursor (1,2); no err; cmd_valid=0.
- From (0,0) strobe 'w','A' with ROWS=COLS=8 -> cursor (7,7). Then 'S','d' -> (0,0).
- Strobe 'G','5','3' then 'F' with cmd_ready=0 -> cursor (5,3); cmd_valid=1, cmd_code=1, cmd_row=5, cmd_col=3 held. Raise cmd_ready one cycle -> cmd_valid=0 next cycle.
- With a reveal pending and cmd_ready=0, strobe 'N' -> err pulse, err_code=2; cmd_code stays 0; cursor unchanged. Then strobe 'R' in the same cycle as cmd_ready=1 -> cmd_valid stays 1 with a fresh reveal at the current cursor.
- Strobe 'G','9' with ROWS=8 -> err, err_code=1, FSM in IDLE, cursor unchanged. Strobe 'G','2',ESC -> no err, cursor unchanged. Strobe 'x' -> err, err_code=0.
- Strobe 'G','4', then drive reset=0 asynchronously mid-cycle -> all outputs 0 immediately. Then release reset and strobe '3' -> err, err_code=0; the FSM did not stay in GOTO_COL.
